load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the ALU.
- Takes the ALU result as the effective address and executes RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) against a single-port data memory with a valid/ready handshake and variable latency.
- Generates byte strobes and lane-replicated store data, sign/zero-extends load data, and stalls the pipeline until the access completes.

Parameters:
- ADDR_WIDTH, 32, width of the effective address and the memory address.
- DATA_WIDTH, 32, data word width. Only 32 is supported; strobe width is DATA_WIDTH/8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  1  the current instruction is a load or store. Held stable by upstream while stall_o=1.
- we_i  input  1  1=store, 0=load.
- funct3_i  input  3  RV32I funct3 of the memory instruction.
- addr_i  input  ADDR_WIDTH  effective address (ALU result).
- wdata_i  input  DATA_WIDTH  store source (rs2 value).
- stall_o  output  1  hold the upstream pipeline.
- done_o  output  1  one-cycle pulse: access complete, rdata_o valid.
- rdata_o  output  DATA_WIDTH  extended load result; 0 for stores.
- err_o  output  1  misaligned address or illegal funct3. Combinational, IDLE only.
- mem_req_o  output  1  memory request valid.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_wstrb_o  output  4  byte write strobes; 0 for loads.
- mem_wdata_o  output  DATA_WIDTH  lane-positioned store data.
- mem_ready_i  input  1  memory accepts/completes the request this cycle.
- mem_rdata_i  input  DATA_WIDTH  read word; valid when mem_ready_i=1 on a load.

Behaviour:
- Reset (synchronous): state=IDLE, mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, done_o=0.
- FSM states:
  - IDLE:
    - If req_i=1 and the access is legal: latch addr, we, funct3 and aligned wdata/strobe; go to BUSY; stall_o=1.
    - If req_i=1 and the access is illegal: err_o=1, stall_o=0, stay in IDLE, no memory request.
  - BUSY:
    - mem_req_o=1, stall_o=1, all mem_* outputs stable.
    - On mem_ready_i=1: register the extended load data into rdata_o (0 for a store) and go to DONE.
  - DONE:
    - done_o=1, stall_o=0, mem_req_o=0; the pipeline advances this cycle.
    - req_i is ignored in DONE (it is the same instruction). Go to IDLE.
- Latency: minimum 3 cycles (IDLE accept, BUSY with immediate ready, DONE); 2 stall cycles plus the memory wait cycles.
- Legality rules:
  - Half access requires addr[0]=0; word access requires addr[1:0]=0.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Anything else is illegal.
- Store formatting, with off = addr[1:0]:
  - SB: wstrb = 4'b0001<<off; wdata = {4{byte}}.
  - SH: wstrb = 4'b0011<<off; wdata = {2{half}}.
  - SW: wstrb = 4'b1111; wdata = word.
- Load extraction:
  - The selected lane is mem_rdata_i >> (8*off).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word.
- mem_ready_i is ignored outside BUSY.
- rdata_o holds its value until the next completed access.
- Reset mid-transaction (BUSY or DONE): next cycle is IDLE with mem_req_o=0. The in-flight access is abandoned; the memory must tolerate request withdrawal on reset.
- Simultaneous rst and mem_ready_i: reset wins, and rdata_o is 0.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Strobe width constant.
- Sub-module lsu_align (combinational). Inputs funct3, offset, wdata, rdata. Outputs wstrb, positioned wdata, extended rdata, illegal flag.
- The top level holds the FSM and registers.

Test Plan:
- SB addr=0x1003, wdata=0x000000A5, ready in the first BUSY cycle -> mem_addr_o=0x1000, wstrb=1000, wdata=0xA5A5A5A5; stall_o high 2 cycles; done_o at cycle 3.
- LB addr=0x2001, mem_rdata_i=0x0000_80FF -> rdata_o=0xFFFFFF80. The same access as LBU -> rdata_o=0x00000080.
- LH addr=0x2002, mem_rdata_i=0x8001_1234, mem_ready_i delayed 4 cycles -> mem_* stable throughout BUSY; stall_o high 5 cycles; rdata_o=0xFFFF8001.
- LW addr=0x3002 -> err_o=1 same cycle, stall_o=0, mem_req_o never asserts. funct3=011 load -> err_o=1.
- Back-to-back SW 0x4000 then LW 0x4000 (memory model) -> second access accepted the cycle after DONE; rdata_o equals the stored word.
- rst asserted in the 2nd BUSY cycle of an LW -> next cycle mem_req_o=0, state IDLE, rdata_o=0, done_o never pulses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // RV32I memory funct3 encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Data word width and the matching byte-strobe width.
    localparam int WORD_WIDTH = 32;
    localparam int STRB_WIDTH = WORD_WIDTH / 8;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store strobes/data replication, load lane extraction and
// extension, and legality of a funct3/offset/direction combination.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic [WORD_WIDTH-1:0] wdata_lane,
    output logic [WORD_WIDTH-1:0] rdata_ext,
    output logic                  illegal
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Halfword accesses are only legal at offset 0 or 2, so offset[1] picks the half.
    assign lane_b = rdata[{offset, 3'b000} +: 8];
    assign lane_h = rdata[{offset[1], 4'b0000} +: 16];

    // Decode funct3 into strobes, replicated write data, extended read data and legality.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wstrb      = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        illegal    = 1'b0;
        case (funct3)
            F3_B: begin
                wstrb      = we ? (4'b0001 << offset) : 4'b0000;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{lane_b[7]}}, lane_b};
            end
            F3_H: begin
                illegal    = offset[0];
                wstrb      = we ? (4'b0011 << offset) : 4'b0000;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{lane_h[15]}}, lane_h};
            end
            F3_W: begin
                illegal    = (offset != 2'b00);
                wstrb      = we ? 4'b1111 : 4'b0000;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
            F3_BU: begin
                illegal    = we;
                rdata_ext  = {24'd0, lane_b};
            end
            F3_HU: begin
                illegal    = we | offset[0];
                rdata_ext  = {16'd0, lane_h};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts a load/store from the pipeline, runs one
// valid/ready access on the data memory and stalls until it completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_wstrb_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    state_t state, next_state;

    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic                  sel_we;
    logic [2:0]            sel_funct3;
    logic [1:0]            sel_offset;
    logic [STRB_WIDTH-1:0] align_wstrb;
    logic [WORD_WIDTH-1:0] align_wdata;
    logic [WORD_WIDTH-1:0] align_rdata;
    logic                  illegal;
    logic                  accept;
    logic                  complete;

    // In IDLE the aligner sees the incoming instruction; afterwards the latched one.
    assign sel_we     = (state == IDLE) ? we_i          : mem_we_o;
    assign sel_funct3 = (state == IDLE) ? funct3_i      : funct3_q;
    assign sel_offset = (state == IDLE) ? addr_i[1:0]   : offset_q;

    lsu_align u_align (
        .we         (sel_we),
        .funct3     (sel_funct3),
        .offset     (sel_offset),
        .wdata      (wdata_i),
        .rdata      (mem_rdata_i),
        .wstrb      (align_wstrb),
        .wdata_lane (align_wdata),
        .rdata_ext  (align_rdata),
        .illegal    (illegal)
    );

    assign accept   = (state == IDLE) && req_i && !illegal;
    assign complete = (state == BUSY) && mem_ready_i;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; req_i is ignored in DONE since it is still the finished instruction.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = BUSY;
            BUSY:    if (complete) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pipeline and memory handshake outputs decoded from the state.
    always_comb begin
        stall_o   = 1'b0;
        done_o    = 1'b0;
        mem_req_o = 1'b0;
        err_o     = 1'b0;
        case (state)
            IDLE: begin
                err_o   = req_i & illegal;
                stall_o = req_i & ~illegal;
            end
            BUSY: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Latch the request on accept and capture the extended load result on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            rdata_o     <= '0;
        end else begin
            if (accept) begin
                mem_we_o    <= we_i;
                mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wstrb_o <= align_wstrb;
                mem_wdata_o <= align_wdata;
                funct3_q    <= funct3_i;
                offset_q    <= addr_i[1:0];
            end
            if (complete) begin
                rdata_o <= mem_we_o ? '0 : align_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    logic [31:0] rdata_drv;
    logic        use_model;
    logic [31:0] model_mem [16];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Read data comes either from a directed value or from the small memory model.
    assign mem_rdata_i = use_model ? model_mem[mem_addr_o[5:2]] : rdata_drv;

    // Memory model: apply strobed writes when a store completes.
    always @(posedge clk) begin
        if (!rst && mem_req_o && mem_ready_i && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb_o[b]) model_mem[mem_addr_o[5:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access: accept in IDLE, `waits` BUSY cycles without ready, then ready, then DONE.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        int stall_cycles;
        stall_cycles = 0;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        rdata_drv = rdata; mem_ready_i = 1'b0;
        #1;
        check({tag, "_accept_stall"}, 32'(stall_o), 32'd1);
        check({tag, "_accept_err"}, 32'(err_o), 32'd0);
        check({tag, "_accept_memreq"}, 32'(mem_req_o), 32'd0);
        stall_cycles += int'(stall_o);
        @(negedge clk);
        for (int i = 0; i <= waits; i++) begin
            mem_ready_i = (i == waits);
            #1;
            check({tag, "_busy_memreq"}, 32'(mem_req_o), 32'd1);
            check({tag, "_busy_done"}, 32'(done_o), 32'd0);
            check({tag, "_busy_addr"}, mem_addr_o, exp_addr);
            check({tag, "_busy_we"}, 32'(mem_we_o), 32'(we));
            check({tag, "_busy_wstrb"}, 32'(mem_wstrb_o), 32'(exp_strb));
            if (we) check({tag, "_busy_wdata"}, mem_wdata_o, exp_wdata);
            stall_cycles += int'(stall_o);
            @(negedge clk);
        end
        mem_ready_i = 1'b0;
        req_i = 1'b0;
        #1;
        check({tag, "_done_pulse"}, 32'(done_o), 32'd1);
        check({tag, "_done_memreq"}, 32'(mem_req_o), 32'd0);
        check({tag, "_rdata"}, rdata_o, exp_rdata);
        stall_cycles += int'(stall_o);
        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(2 + waits));
        @(negedge clk);
        #1;
        check({tag, "_done_cleared"}, 32'(done_o), 32'd0);
        check({tag, "_rdata_hold"}, rdata_o, exp_rdata);
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = F3_W; addr_i = '0;
        wdata_i = '0; mem_ready_i = 1'b0; rdata_drv = '0; use_model = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_memreq", 32'(mem_req_o), 32'd0);
        check("rst_memwe", 32'(mem_we_o), 32'd0);
        check("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stores: byte at the top lane, halfword in the upper half.
        access("sb", 1'b1, F3_B, 32'h1003, 32'h0000_00A5, 32'h0, 0,
               32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("sh", 1'b1, F3_H, 32'h1002, 32'h1234_ABCD, 32'h0, 0,
               32'h1000, 4'b1100, 32'hABCD_ABCD, 32'h0);

        // Loads with sign and zero extension.
        access("lb", 1'b0, F3_B, 32'h2001, 32'h0, 32'h0000_80FF, 0,
               32'h2000, 4'b0000, 32'h0, 32'hFFFF_FF80);
        access("lbu", 1'b0, F3_BU, 32'h2001, 32'h0, 32'h0000_80FF, 0,
               32'h2000, 4'b0000, 32'h0, 32'h0000_0080);
        access("lh_wait", 1'b0, F3_H, 32'h2002, 32'h0, 32'h8001_1234, 3,
               32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001);
        access("lhu", 1'b0, F3_HU, 32'h2002, 32'h0, 32'h8001_1234, 1,
               32'h2000, 4'b0000, 32'h0, 32'h0000_8001);
        access("lw", 1'b0, F3_W, 32'h2000, 32'h0, 32'h8001_1234, 0,
               32'h2000, 4'b0000, 32'h0, 32'h8001_1234);

        // Illegal accesses: flagged combinationally, no request, stay IDLE.
        req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h3002;
        #1;
        check("mis_lw_err", 32'(err_o), 32'd1);
        check("mis_lw_stall", 32'(stall_o), 32'd0);
        check("mis_lw_memreq", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        #1;
        check("mis_lw_state", 32'(dut.state), 32'(IDLE));
        check("mis_lw_memreq2", 32'(mem_req_o), 32'd0);
        funct3_i = 3'b011; addr_i = 32'h3000;
        #1;
        check("bad_f3_load_err", 32'(err_o), 32'd1);
        we_i = 1'b1; funct3_i = F3_BU;
        #1;
        check("bad_f3_store_err", 32'(err_o), 32'd1);
        we_i = 1'b0; funct3_i = F3_H; addr_i = 32'h3001;
        #1;
        check("mis_lh_err", 32'(err_o), 32'd1);
        req_i = 1'b0;
        #1;
        check("noreq_err", 32'(err_o), 32'd0);
        @(negedge clk);
        #1;
        check("illegal_state", 32'(dut.state), 32'(IDLE));

        // Back-to-back accesses against the memory model.
        use_model = 1'b1;
        access("sw_m", 1'b1, F3_W, 32'h4000, 32'hDEAD_BEEF, 32'h0, 0,
               32'h4000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        access("lw_m", 1'b0, F3_W, 32'h4000, 32'h0, 32'h0, 0,
               32'h4000, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        access("sb_m", 1'b1, F3_B, 32'h4001, 32'h0000_0077, 32'h0, 1,
               32'h4000, 4'b0010, 32'h7777_7777, 32'h0);
        access("lw_m2", 1'b0, F3_W, 32'h4000, 32'h0, 32'h0, 0,
               32'h4000, 4'b0000, 32'h0, 32'hDEAD_77EF);

        // Reset in the second BUSY cycle, coinciding with mem_ready_i.
        req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h4000; mem_ready_i = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_busy1", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b1; mem_ready_i = 1'b1; req_i = 1'b0;
        #1;
        check("rstmid_busy2", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b0; mem_ready_i = 1'b0;
        #1;
        check("rstmid_memreq", 32'(mem_req_o), 32'd0);
        check("rstmid_state", 32'(dut.state), 32'(IDLE));
        check("rstmid_rdata", rdata_o, 32'd0);
        check("rstmid_done", 32'(done_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstmid_no_done", 32'(done_o), 32'd0);
            check("rstmid_idle", 32'(mem_req_o), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
